operand_entry_ctrl: RTL

//  Sequences operand entry for the FPGA adder from the 4x4 matrix keypad.

---
 rtl/operand_entry_ctrl_if.sv | 27 ++
 rtl/operand_entry_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/operand_entry_ctrl_if.sv
// Keypad-to-adder operand entry bus.
// master: the entry controller (consumes key strobes and add_done, drives operands/display).
// slave:  the surrounding system (keypad scanner, adder and display).
interface operand_entry_ctrl_if #(
    parameter int unsigned NDIG = 3,
    parameter int unsigned W    = 10
);
    logic                 key_valid;
    logic [3:0]           key_code;
    logic                 add_done;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic                 start;
    logic [4*NDIG-1:0]    disp_bcd;
    logic [1:0]           phase;
    logic                 busy;

    modport master (
        input  key_valid, key_code, add_done,
        output op_a, op_b, start, disp_bcd, phase, busy
    );

    modport slave (
        output key_valid, key_code, add_done,
        input  op_a, op_b, start, disp_bcd, phase, busy
    );
endinterface

// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer for the keypad adder.
// Collects NDIG decimal digits for operand A, then operand B, converts each
// BCD entry to binary (MS digit first, one digit per cycle), pulses start and
// waits for the adder's done.
// Optional build macro ENTRY_TIMEOUT_EN: idle-key timeout that acts as key C.
module operand_entry_ctrl #(
    parameter int unsigned NDIG        = 3,
    parameter int unsigned W           = 10,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input logic                  clk,
    input logic                  rst,
    operand_entry_ctrl_if.master bus
);
    localparam int unsigned DW = 4 * NDIG;
    localparam int unsigned CW = $clog2(NDIG + 1);

    // Reject parameter sets where the converted value could overflow W bits.
    if (NDIG < 1 || TIMEOUT_CYC < 1 ||
        (64'd1 << W) <= (64'(10 ** NDIG) - 64'd1)) begin : g_param_check
        $error("operand_entry_ctrl: illegal NDIG/W/TIMEOUT_CYC combination");
    end

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        CONV_A,
        CONV_B,
        WAIT_ADD,
        SHOW
    } state_t;

    state_t          state;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    acc;
    logic [W-1:0]    acc_next;
    logic [DW-1:0]   disp_bcd;
    logic [DW-1:0]   conv_sr;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   conv_left;
    logic            start;
    logic            busy;
    logic [1:0]      phase;

    logic            key_digit;
    logic            key_enter;
    logic            key_back;
    logic            key_clr;
    logic            clr_evt;
    logic            timeout_hit;

    // Key decode, qualified by the strobe.
    always_comb begin
        key_digit = bus.key_valid && (bus.key_code <= 4'd9);
        key_enter = bus.key_valid && (bus.key_code == 4'hA);
        key_back  = bus.key_valid && (bus.key_code == 4'hB);
        key_clr   = bus.key_valid && (bus.key_code == 4'hC);
        clr_evt   = key_clr || timeout_hit;
    end

    // One conversion step: acc*10 + next digit (digits leave conv_sr MS first).
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + W'(conv_sr[DW-1 -: 4]);
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_cnt;
    logic          idle_active;

    assign idle_active = (state == ENTER_A) || (state == ENTER_B) || (state == SHOW);
    assign timeout_hit = idle_active && !bus.key_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));

    // Idle-cycle counter: cleared by any key, frozen outside entry/show states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (idle_active) begin
            if (bus.key_valid || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Entry FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ENTER_A;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            disp_bcd  <= '0;
            conv_sr   <= '0;
            cnt       <= '0;
            conv_left <= '0;
            start     <= 1'b0;
            busy      <= 1'b0;
            phase     <= 2'd0;
        end else begin
            start <= 1'b0;
            case (state)
                ENTER_A, ENTER_B: begin
                    if (clr_evt) begin
                        op_a     <= '0;
                        disp_bcd <= '0;
                        cnt      <= '0;
                        state    <= ENTER_A;
                        phase    <= 2'd0;
                    end else if (key_digit) begin
                        if (cnt != CW'(NDIG)) begin
                            disp_bcd <= (disp_bcd << 4) | DW'(bus.key_code);
                            cnt      <= cnt + 1'b1;
                        end
                    end else if (key_back) begin
                        if (cnt != '0) begin
                            disp_bcd <= disp_bcd >> 4;
                            cnt      <= cnt - 1'b1;
                        end
                    end else if (key_enter && (cnt != '0)) begin
                        // Convert from a private copy so the display stays put while busy.
                        conv_sr   <= disp_bcd;
                        acc       <= '0;
                        conv_left <= CW'(NDIG);
                        busy      <= 1'b1;
                        state     <= (state == ENTER_A) ? CONV_A : CONV_B;
                    end
                end

                CONV_A, CONV_B: begin
                    conv_sr   <= conv_sr << 4;
                    acc       <= acc_next;
                    conv_left <= conv_left - 1'b1;
                    if (conv_left == CW'(1)) begin
                        busy     <= 1'b0;
                        disp_bcd <= '0;
                        cnt      <= '0;
                        if (state == CONV_A) begin
                            op_a  <= acc_next;
                            state <= ENTER_B;
                            phase <= 2'd1;
                        end else begin
                            op_b  <= acc_next;
                            start <= 1'b1;
                            state <= WAIT_ADD;
                            phase <= 2'd2;
                        end
                    end
                end

                WAIT_ADD: begin
                    if (key_clr) begin
                        op_a  <= '0;
                        op_b  <= '0;
                        state <= ENTER_A;
                        phase <= 2'd0;
                    end else if (bus.add_done) begin
                        state <= SHOW;
                        phase <= 2'd3;
                    end
                end

                SHOW: begin
                    if (clr_evt) begin
                        op_a     <= '0;
                        op_b     <= '0;
                        disp_bcd <= '0;
                        cnt      <= '0;
                        state    <= ENTER_A;
                        phase    <= 2'd0;
                    end else if (key_digit) begin
                        op_a     <= '0;
                        op_b     <= '0;
                        disp_bcd <= DW'(bus.key_code);
                        cnt      <= CW'(1);
                        state    <= ENTER_A;
                        phase    <= 2'd0;
                    end
                end

                default: begin
                    state <= ENTER_A;
                    busy  <= 1'b0;
                    phase <= 2'd0;
                end
            endcase
        end
    end

    assign bus.op_a     = op_a;
    assign bus.op_b     = op_b;
    assign bus.start    = start;
    assign bus.disp_bcd = disp_bcd;
    assign bus.phase    = phase;
    assign bus.busy     = busy;
endmodule
